// File: rtl/array_pkg.sv
// Shared types and size helpers for the array reader.
// Holds the sweep FSM encoding and the derived widths.
package array_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      DONE
   } state_t;

   // Sizes for the default build (W=2, K=3*W).
   localparam int W_DEF = 2;
   localparam int K_DEF = 3 * W_DEF;
   localparam int N     = (1 << W_DEF) - 1;
   localparam int SUMW  = K_DEF + W_DEF + 1;

   // Same quantities for any parameterisation.
   function automatic int last_addr(input int w);
      return (1 << w) - 1;
   endfunction

   function automatic int sum_width(input int w, input int k);
      return k + w + 1;
   endfunction

endpackage

// File: rtl/array_mem.sv
// 2^W x (K+1) register array: one write port, one comb read port.
// Ports: clk, rst (async clear), wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module array_mem
   import array_pkg::*;
#(
   parameter int W = 2,
   parameter int K = 3 * W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_addr,
   input  logic [K:0]   wr_data,
   input  logic [W-1:0] rd_addr,
   output logic [K:0]   rd_data
);

   localparam int DEPTH = last_addr(W) + 1;

   logic [K:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Comb read: a same-edge write lands after the fetch samples it,
   // so the fetch always sees the old value.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/array_reader.sv
// Sweeps the register array in address order over valid/ready,
// summing accepted beats. Ports: write port, start, out_* stream,
// sum, busy, done.
module array_reader
   import array_pkg::*;
#(
   parameter int W = 2,
   parameter int K = 3 * W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_addr,
   input  logic [K:0]   wr_data,
   input  logic         start,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_addr,
   output logic [K:0]   out_data,
   output logic         out_last,
   output logic [K+W:0] sum,
   output logic         busy,
   output logic         done
);

   localparam int SW = sum_width(W, K);
   localparam logic [W-1:0] LAST = W'(last_addr(W));

   state_t     state;
   state_t     state_n;
   logic [W-1:0] ptr;
   logic [K:0]   rd_data;
   logic         fire;

   array_mem #(
      .W (W),
      .K (K)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (ptr),
      .rd_data (rd_data)
   );

   assign fire = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = FETCH;
            end
         end
         FETCH: begin
            state_n = SEND;
         end
         SEND: begin
            if (fire) begin
               state_n = (ptr == LAST) ? DONE : FETCH;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_comb begin
      out_valid = (state == SEND);
      busy      = (state != IDLE);
      done      = (state == DONE);
      out_last  = (state == SEND) && (out_addr == LAST);
   end

   // Beat registers only load in FETCH, so they hold through
   // backpressure and ignore writes to the entry in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         out_addr <= '0;
         out_data <= '0;
         sum      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  ptr <= '0;
                  sum <= '0;
               end
            end
            FETCH: begin
               out_data <= rd_data;
               out_addr <= ptr;
            end
            SEND: begin
               if (fire) begin
                  sum <= sum + SW'(out_data);
                  if (ptr != LAST) begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/array_reader.md
# array_reader

Read-side companion to the array-update benchmark blocks. Holds a 2^W-entry register array written through a simple write port. On `start`, it sweeps every entry in address order and streams each one out over a valid/ready handshake. It also accumulates a running sum and pulses `done` when the sweep completes, so the contents written by an update engine can be drained and checked.

## Interface
- `W`, default 2: address width; array depth is 2^W entries.
- `K`, default 3*W: MSB index of an entry; entries are K+1 bits wide.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  W  write address.
- `wr_data`  in  K+1  write data.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_addr`  out  W  address of the current beat.
- `out_data`  out  K+1  entry value of the current beat.
- `out_last`  out  1  high with the beat for address 2^W-1.
- `sum`  out  K+W+1  sum of entries accepted in the current or last sweep.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Storage: 2^W x (K+1) registers, cleared to 0 by `rst`.
- Writes: `wr_en` writes `wr_data` to `wr_addr` on the clock edge, in every state.
- FSM states: IDLE, FETCH, SEND, DONE.
  - IDLE: `start` goes to FETCH, clears `sum`, and sets the pointer to 0. `start` in any other state is ignored.
  - FETCH: latches `mem[ptr]` into `out_data` and `ptr` into `out_addr`, then goes to SEND.
  - SEND: `out_valid`=1. On `out_valid & out_ready`:
    - `sum` += `out_data`, zero-extended.
    - If `ptr` == 2^W-1, go to DONE. Otherwise increment `ptr` and go to FETCH.
  - DONE: `done`=1 for one cycle, then IDLE.
- Read-before-write: if FETCH reads an address written in the same cycle, the old value is fetched.
  - A write to an address not yet fetched is visible to the sweep.
  - A write to the entry currently held in SEND does not change `out_data`.
- `out_data`, `out_addr` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
- `sum` width K+W+1 cannot overflow: max value is 2^W x (2^(K+1)-1).
- `sum` holds its value after DONE until the next `start`.

## Timing
- Reset values: `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `sum`=0, `busy`=0, `done`=0, state IDLE, array all zero.
- `rst` mid-sweep aborts immediately, with no partial `done`.
- With `start` sampled at edge 0:
  - FETCH runs in cycle 1.
  - The first `out_valid` is in cycle 2.
- Each beat costs 2 cycles (FETCH + SEND) with `out_ready` held high.
- Full sweep with no backpressure: the last beat is in cycle 2^(W+1), `done` in cycle 2^(W+1)+1, and `busy` falls the cycle after.
- `busy` rises in the cycle after `start` is accepted.
- `start` coincident with `done` is ignored; a new sweep needs `start` in IDLE.

## Structure
- Package `array_pkg`:
  - the state enum {IDLE, FETCH, SEND, DONE};
  - the helper localparams N = 2^W-1 and SUMW = K+W+1.
- Sub-module `array_mem`: the register array with its write port, combinational read at `ptr`, and async clear.
- FSM, pointer and sum logic live in `array_reader`.

## Test plan
Defaults apply (W=2, K=6): 4 entries, 7-bit data.
- Basic sweep: write 1, 2, 3, 127 to addrs 0–3; `start`; `out_ready`=1.
  - Beats (addr, data) are (0,1), (1,2), (2,3), (3,127), with `out_last` only on addr 3.
  - `sum`=133 and `done` pulses once, in cycle 9.
- Backpressure: same data, `out_ready` low for 3 cycles during beat 1.
  - `out_data`=2 and `out_addr`=1 are held stable throughout.
  - `sum`=133; `done` is delayed by 3 cycles.
- Write during sweep:
  - Writing 9 to addr 2 while beat 0 is in SEND makes beat 2 carry 9, and `sum`=139.
  - Writing 50 to addr 1 while beat 1 is in SEND leaves beat 1 carrying 2.
- Start while busy: pulse `start` in cycle 4 of a sweep.
  - The sweep is unaffected, `sum` is not cleared, and there is exactly one `done`.
- Reset mid-sweep: assert `rst` during beat 2.
  - All outputs return to reset values at once, and no `done` appears.
  - A following sweep yields four zero beats with `sum`=0.
- Max values: write 127 to all 4 entries; sweep gives `sum`=508 with no truncation.
